bch_syndrome_sched: RTL and testbench

- Round-robin scheduler that shares one bch_syndrome engine among CHANNELS codeword sources.
- Grants one source a whole codeword (WORDS data words) and drives the engine's start/ce/data_in. It then flushes the engine pipeline and captures the syndromes into a single result slot with valid/ready handshake.
- Sits between the per-channel receive buffers and the bch_errors_present / bch_syndrome_shuffle / key-equation stage.

---
 rtl/bch_syndrome_sched.sv | 165 ++++++++++++++++
 tb/tb_bch_syndrome_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_syndrome_sched.sv
`default_nettype none
// ============================================================================
// Module  : bch_syndrome_sched
// Purpose : Round-robin scheduler sharing one bch_syndrome engine among
//           CHANNELS codeword sources, with a single valid/ready result slot.
// Macro   : BCH_SCHED_DROP_CLEAN_EN drops error-free codewords (no result).
// Revision: 1.0
// ============================================================================
module bch_syndrome_sched #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 8,
  parameter int WORDS    = 32,
  parameter int SYN_W    = 36
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          req_valid,
  input  logic [CHANNELS*BITS-1:0]     req_data,
  output logic [CHANNELS-1:0]          req_ready,
  output logic                         eng_start,
  output logic                         eng_ce,
  output logic [BITS-1:0]              eng_data,
  input  logic                         eng_ready,
  input  logic                         eng_done,
  input  logic [SYN_W-1:0]             eng_syndromes,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(CHANNELS)-1:0]  res_chan,
  output logic [SYN_W-1:0]             res_syndromes,
  output logic                         res_errors,
  output logic [15:0]                  clean_count
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CH_W-1:0]     rr;
  logic [CH_W-1:0]     grant;
  logic [CNT_W-1:0]    cnt;
  logic                arb_found;
  logic [CH_W-1:0]     arb_chan;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_go;
  logic                grant_valid;
  logic                last_word;
  logic                done_now;
  logic                syn_clean;
  logic                drop_now;
  logic [CHANNELS-1:0] gnt_mask;
  logic [BITS-1:0]     feed_data;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_mask
      assign gnt_mask[c] = (grant == CH_W'(c));
    end
  endgenerate

  // Search upward from rr+1, wrapping at CHANNELS (not at 2**CH_W).
  always_comb begin
    arb_found = 1'b0;
    arb_chan  = '0;
    arb_idx   = rr;
    for (int i = 0; i < CHANNELS; i++) begin
      arb_idx = (arb_idx == CH_W'(CHANNELS - 1)) ? '0 : arb_idx + CH_W'(1);
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_chan  = arb_idx;
      end
    end
  end

  always_comb begin
    feed_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt_mask[c]) feed_data = req_data[c*BITS +: BITS];
    end
  end

  assign grant_valid = |(req_valid & gnt_mask);
  assign arb_go      = eng_ready && !res_valid && arb_found;
  assign last_word   = (cnt == CNT_W'(WORDS - 1));
  assign syn_clean   = (eng_syndromes == '0);
  assign done_now    = (state == S_FLUSH) && eng_done;

`ifdef BCH_SCHED_DROP_CLEAN_EN
  assign drop_now = syn_clean;
`else
  assign drop_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_go)                  state_nxt = S_FEED;
      S_FEED:  if (grant_valid && last_word) state_nxt = S_FLUSH;
      S_FLUSH: if (eng_done)                state_nxt = drop_now ? S_IDLE : S_HOLD;
      S_HOLD:  if (res_valid && res_ready)  state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  // Engine strobes are forced low while reset is asserted, whatever the state.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    eng_ce    = 1'b0;
    eng_data  = '0;
    if (reset_n) begin
      case (state)
        S_FEED: begin
          req_ready = gnt_mask;
          eng_ce    = grant_valid;
          eng_start = grant_valid && (cnt == '0);
          eng_data  = feed_data;
        end
        S_FLUSH: eng_ce = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr            <= CH_W'(CHANNELS - 1);
      grant         <= '0;
      cnt           <= '0;
      res_valid     <= 1'b0;
      res_chan      <= '0;
      res_syndromes <= '0;
      res_errors    <= 1'b0;
      clean_count   <= '0;
    end else begin
      if (state == S_IDLE && arb_go) begin
        grant <= arb_chan;
        rr    <= arb_chan;
        cnt   <= '0;
      end
      if (state == S_FEED && grant_valid) cnt <= cnt + CNT_W'(1);
      if (done_now) begin
        if (syn_clean && clean_count != 16'hFFFF) clean_count <= clean_count + 16'd1;
        if (!drop_now) begin
          res_syndromes <= eng_syndromes;
          res_chan      <= grant;
          res_errors    <= |eng_syndromes;
          res_valid     <= 1'b1;
        end
      end
      if (state == S_HOLD && res_valid && res_ready) res_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_sched.sv
`default_nettype none
// tb_bch_syndrome_sched: randomized sources, behavioural syndrome engine and a
// result scoreboard checked by an independent monitor.
module tb_bch_syndrome_sched;

  localparam int CHANNELS = 4;
  localparam int BITS     = 8;
  localparam int WORDS    = 32;
  localparam int SYN_W    = 36;
  localparam int CH_W     = 2;
  localparam int LAT      = 3;

  typedef logic [BITS-1:0] cw_t [WORDS];
  typedef struct packed {
    logic [CH_W-1:0]  chan;
    logic [SYN_W-1:0] syn;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [CHANNELS-1:0]      req_valid;
  logic [CHANNELS*BITS-1:0] req_data;
  logic [CHANNELS-1:0]      req_ready;
  logic                     eng_start, eng_ce, eng_ready, eng_done;
  logic [BITS-1:0]          eng_data;
  logic [SYN_W-1:0]         eng_syndromes;
  logic                     res_valid, res_ready, res_errors;
  logic [CH_W-1:0]          res_chan;
  logic [SYN_W-1:0]         res_syndromes;
  logic [15:0]              clean_count;

  always #5 clk = ~clk;

  bch_syndrome_sched #(.CHANNELS(CHANNELS), .BITS(BITS), .WORDS(WORDS), .SYN_W(SYN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_start(eng_start), .eng_ce(eng_ce), .eng_data(eng_data),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_syndromes(eng_syndromes),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_syndromes(res_syndromes), .res_errors(res_errors), .clean_count(clean_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Stand-in syndrome: rotate-and-fold, zero for an all-zero codeword.
  function automatic logic [SYN_W-1:0] syn_step(input logic [SYN_W-1:0] s, input logic [BITS-1:0] w);
    return {s[SYN_W-6:0], s[SYN_W-1:SYN_W-5]} ^ {w, 20'd0, w};
  endfunction

  function automatic logic [SYN_W-1:0] cw_syn(input cw_t w);
    logic [SYN_W-1:0] s = '0;
    for (int i = 0; i < WORDS; i++) s = syn_step(s, w[i]);
    return s;
  endfunction

  // Behavioural engine: WORDS data words, then LAT flush ce cycles, then done.
  logic [SYN_W-1:0] e_syn = '0;
  int               e_cnt = WORDS + 1;
  int               e_fl  = 0;
  logic             e_done = 1'b0;
  logic             spur;

  always @(posedge clk) begin
    e_done <= 1'b0;
    if (eng_ce) begin
      if (eng_start) begin
        e_syn <= syn_step('0, eng_data);
        e_cnt <= 1;
        e_fl  <= 0;
      end else if (e_cnt < WORDS) begin
        e_syn <= syn_step(e_syn, eng_data);
        e_cnt <= e_cnt + 1;
      end else if (e_cnt == WORDS) begin
        if (e_fl == LAT - 1) begin
          e_done <= 1'b1;
          e_cnt  <= WORDS + 1;
        end
        e_fl <= e_fl + 1;
      end
    end
  end

  assign eng_done      = e_done | spur;
  assign eng_syndromes = e_syn;

  logic [BITS-1:0] wq [CHANNELS][$];
  exp_t            sb[$];
  int              grant_log[$];
  int              pos[CHANNELS];
  int              wic[CHANNELS];
  int              gap[CHANNELS];
  int              gap_sum[CHANNELS];
  int              stall_at[CHANNELS];
  int              stall_len[CHANNELS];
  int              rnd_gap;
  int              clean_exp;
  logic            hold_block;

  // Source driver: presents each channel's queued words, inserting stall gaps.
  initial begin : driver
    logic [CHANNELS-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    eng_ready = 1'b1;
    res_ready = 1'b0;
    spur      = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      pos[c] = 0; wic[c] = 0; gap[c] = 0; gap_sum[c] = 0;
    end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!reset_n) begin
          wic[c] = 0;
          gap[c] = 0;
        end else if (acc[c] && wq[c].size() > 0) begin
          void'(wq[c].pop_front());
          pos[c]++;
          wic[c]++;
          if (wic[c] == 1) gap_sum[c] = 0;
          if (wic[c] == WORDS) wic[c] = 0;
          else begin
            if (wic[c] == stall_at[c] + 1) gap[c] = stall_len[c];
            else if (rnd_gap > 0 && $urandom_range(99) < rnd_gap) gap[c] = $urandom_range(3, 1);
            gap_sum[c] += gap[c];
          end
        end else if (gap[c] > 0) gap[c]--;
        req_valid[c] = (wq[c].size() > 0) && (gap[c] == 0);
        req_data[c*BITS +: BITS] = (wq[c].size() > 0) ? wq[c][0] : '0;
      end
      eng_ready = ($urandom_range(7) != 0);
      res_ready = !hold_block && ($urandom_range(2) != 0);
      spur      = (e_cnt < WORDS) && ($urandom_range(15) == 0);
    end
  end

  // Monitor: arbitration model, feed/flush protocol and result scoreboard.
  initial begin : monitor
    int                  last_g = CHANNELS - 1;
    int                  arb_exp = 0;
    int                  g = 0;
    int                  fw = 0;
    int                  lowc = 0;
    int                  idx;
    logic                arb_pend = 1'b0;
    logic [CHANNELS-1:0] prev_ready = '0;
    logic                prev_rv = 1'b0;
    logic                prev_acc = 1'b0;
    logic [SYN_W-1:0]    prev_syn = '0;
    logic [CH_W-1:0]     prev_chan = '0;
    logic                prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_g = CHANNELS - 1;
        arb_pend = 1'b0;
        prev_ready = '0;
        prev_rv = 1'b0;
        prev_acc = 1'b0;
      end else begin
        if (arb_pend) begin
          check("grant", req_ready, 64'(1) << arb_exp);
          last_g = arb_exp;
          g = arb_exp;
          fw = 0;
          lowc = 0;
          grant_log.push_back(arb_exp);
        end else if (req_ready != '0 && prev_ready == '0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant: actual req_ready=%b required no grant this cycle", req_ready);
        end

        if (req_ready != '0) begin
          check("ready_onehot", req_ready, 64'(1) << g);
          check("ce_vs_valid", eng_ce, req_valid[g]);
          if (eng_ce) begin
            check("start_word0", eng_start, fw == 0);
            check("feed_data", eng_data, req_data[g*BITS +: BITS]);
            fw++;
          end else lowc++;
        end else begin
          if (prev_ready != '0) begin
            check("words_per_cw", fw, WORDS);
            check("stall_cycles", lowc, gap_sum[g]);
          end
          if (eng_ce) check("flush_data", {eng_start, eng_data}, '0);
        end

        if (res_valid) begin
          if (prev_rv && !prev_acc) begin
            check("hold_syn", res_syndromes, prev_syn);
            check("hold_chan", res_chan, prev_chan);
            check("hold_err", res_errors, prev_err);
          end
          if (res_ready) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].chan == res_chan) idx = i;
            if (idx < 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result: actual chan=%0d syn=%0h required no result", res_chan, res_syndromes);
            end else begin
              check("res_syndromes", res_syndromes, sb[idx].syn);
              check("res_errors", res_errors, |sb[idx].syn);
              sb.delete(idx);
            end
          end
        end

        arb_pend = 1'b0;
        if (req_ready == '0 && !eng_ce && !res_valid && eng_ready && req_valid != '0) begin
          arb_pend = 1'b1;
          for (int i = CHANNELS; i >= 1; i--)
            if (req_valid[(last_g + i) % CHANNELS]) arb_exp = (last_g + i) % CHANNELS;
        end
        prev_ready = req_ready;
        prev_rv    = res_valid;
        prev_acc   = res_valid && res_ready;
        prev_syn   = res_syndromes;
        prev_chan  = res_chan;
        prev_err   = res_errors;
      end
    end
  end

  task automatic push_cw(input int c, input cw_t w);
    exp_t e;
    e.chan = CH_W'(c);
    e.syn  = cw_syn(w);
    if (e.syn == '0) clean_exp++;
`ifdef BCH_SCHED_DROP_CLEAN_EN
    if (e.syn != '0) sb.push_back(e);
`else
    sb.push_back(e);
`endif
    for (int i = 0; i < WORDS; i++) wq[c].push_back(w[i]);
  endtask

  function automatic cw_t rand_cw();
    cw_t w;
    for (int i = 0; i < WORDS; i++) w[i] = BITS'($urandom);
    w[0][0] = 1'b1;
    return w;
  endfunction

  function automatic logic busy();
    logic b = (sb.size() > 0) || res_valid;
    for (int c = 0; c < CHANNELS; c++) if (wq[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: actual still busy after %0d cycles, required idle", t);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin : main
    int   exp_order[6] = '{0, 1, 3, 0, 1, 3};
    int   base;
    int   t;
    cw_t  cw_a;
    cw_t  zero_cw;
    reset_n    = 1'b0;
    hold_block = 1'b0;
    rnd_gap    = 0;
    clean_exp  = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      stall_at[c] = -1;
      stall_len[c] = 0;
    end
    for (int i = 0; i < WORDS; i++) zero_cw[i] = '0;

    // Requests pending during reset must not be accepted.
    for (int k = 0; k < 2; k++) begin
      push_cw(0, rand_cw());
      push_cw(1, rand_cw());
      push_cw(3, rand_cw());
    end
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_ce", eng_ce, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_chan", res_chan, 0);
    check("rst_res_syndromes", res_syndromes, 0);
    check("rst_res_errors", res_errors, 0);
    check("rst_clean_count", clean_count, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    wait_idle();
    check("grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("grant_order", grant_log[i], exp_order[i]);

    // Single streaming channel, then the same codeword with a 5-cycle stall.
    cw_a = rand_cw();
    push_cw(2, cw_a);
    wait_idle();
    stall_at[1]  = 10;
    stall_len[1] = 5;
    push_cw(1, cw_a);
    wait_idle();
    stall_at[1] = -1;

    // Consumer back-pressure with another channel waiting.
    hold_block = 1'b1;
    push_cw(0, rand_cw());
    t = 0;
    while (!res_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("hold_result_seen", res_valid, 1);
    push_cw(3, rand_cw());
    repeat (20) @(negedge clk);
    check("hold_valid_kept", res_valid, 1);
    hold_block = 1'b0;
    wait_idle();

    // Reset in the middle of a codeword.
    base = pos[0];
    push_cw(0, rand_cw());
    t = 0;
    while (pos[0] < base + 15 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("mid_words_reached", pos[0] - base, 15);
    @(posedge clk);
    #2 reset_n = 1'b0;
    for (int c = 0; c < CHANNELS; c++) wq[c].delete();
    sb.delete();
    clean_exp = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    grant_log.delete();
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_clean_count", clean_count, 0);
    push_cw(3, rand_cw());
    push_cw(0, rand_cw());
    wait_idle();
    check("first_grant_after_reset", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Error-free codeword.
    push_cw(1, zero_cw);
    wait_idle();
    check("clean_count_one", clean_count, clean_exp);

    // Random mix with stalls and clean codewords.
    rnd_gap = 20;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(4) == 0) push_cw($urandom_range(CHANNELS - 1), zero_cw);
      else push_cw($urandom_range(CHANNELS - 1), rand_cw());
      repeat ($urandom_range(20)) @(negedge clk);
    end
    wait_idle();
    check("clean_count_final", clean_count, clean_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
